peri_reg_initiator: RTL and testbench

Register-bus initiator for the peripheral subsystem. It accepts single Wishbone-classic transfers from the SoC interconnect and drives the peripheral register bus (chip-select, write, 11-bit address, data, byte enables) that the peripheral-top decode and its RTC/D2A/IR/stepper responders consume. It also waits for the responder's `reg_ack` and returns read data. A bounded timeout converts a missing acknowledge into a Wishbone error, so the interconnect never hangs on an unmapped or dead slot.

---
 rtl/peri_reg_initiator_pkg.sv | 23 ++
 rtl/peri_reg_initiator_if.sv | 53 +++++
 rtl/peri_reg_initiator.sv | 137 +++++++++++++
 tb/tb_peri_reg_initiator.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/peri_reg_initiator_pkg.sv
// Shared types and constants for the peripheral register-bus initiator.
`timescale 1ns/1ps
package peri_reg_pkg;

  // Transfer sequencing: accept, wait for the responder, return the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } peri_reg_state_t;

  // Width of the peripheral register-bus byte address.
  localparam int PERI_REG_AW = 11;

  // Read data returned when a responder never acknowledges.
  localparam logic [31:0] PERI_REG_ERR_DATA = 32'hDEAD_BEEF;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : (val + 8'd1);
  endfunction

endpackage

// File: rtl/peri_reg_initiator_if.sv
// Bus bundles for the initiator: the Wishbone-classic side facing the SoC
// interconnect, and the peripheral register bus facing the responders.
`timescale 1ns/1ps

interface peri_wb_if;
  import peri_reg_pkg::*;

  logic                   wbs_cyc_i;
  logic                   wbs_stb_i;
  logic                   wbs_we_i;
  logic [PERI_REG_AW-1:0] wbs_adr_i;
  logic [31:0]            wbs_dat_i;
  logic [3:0]             wbs_sel_i;
  logic [31:0]            wbs_dat_o;
  logic                   wbs_ack_o;
  logic                   wbs_err_o;

  // Interconnect side issuing requests.
  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o
  );

  // Initiator side accepting requests.
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o
  );
endinterface

interface peri_regbus_if;
  import peri_reg_pkg::*;

  logic                   reg_cs;
  logic                   reg_wr;
  logic [PERI_REG_AW-1:0] reg_addr;
  logic [31:0]            reg_wdata;
  logic [3:0]             reg_be;
  logic [31:0]            reg_rdata;
  logic                   reg_ack;

  // Initiator driving the register bus.
  modport master (
    output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
    input  reg_rdata, reg_ack
  );

  // Decode / responder side.
  modport slave (
    input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
    output reg_rdata, reg_ack
  );
endinterface

// File: rtl/peri_reg_initiator.sv
// Wishbone-classic to peripheral register-bus initiator. One transfer at a
// time; a bounded wait turns a missing reg_ack into a Wishbone error so the
// interconnect cannot hang on an unmapped or dead slot. Every output comes
// straight from a flop.
`timescale 1ns/1ps

module peri_reg_initiator
  import peri_reg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 32'd255,
  parameter logic [31:0] ERR_DATA    = PERI_REG_ERR_DATA
) (
  input  logic          mclk,
  input  logic          s_reset_n,
  peri_wb_if.slave      wb,
  peri_regbus_if.master rb,
  output logic [7:0]    tout_cnt
);

  // Timer value at which an unacknowledged transfer is abandoned.
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYC);

  peri_reg_state_t        state_q,     state_d;
  logic                   reg_cs_q,    reg_cs_d;
  logic                   reg_wr_q,    reg_wr_d;
  logic [PERI_REG_AW-1:0] reg_addr_q,  reg_addr_d;
  logic [31:0]            reg_wdata_q, reg_wdata_d;
  logic [3:0]             reg_be_q,    reg_be_d;
  logic [7:0]             timer_q,     timer_d;
  logic                   wbs_ack_q,   wbs_ack_d;
  logic                   wbs_err_q,   wbs_err_d;
  logic [31:0]            wbs_dat_q,   wbs_dat_d;
  logic [7:0]             tout_cnt_q,  tout_cnt_d;

  // State and output registers; reset clears everything asynchronously so a
  // mid-transfer reset releases the register bus at once.
  always_ff @(posedge mclk or negedge s_reset_n) begin
    if (!s_reset_n) begin
      state_q     <= IDLE;
      reg_cs_q    <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_addr_q  <= {PERI_REG_AW{1'b0}};
      reg_wdata_q <= 32'd0;
      reg_be_q    <= 4'd0;
      timer_q     <= 8'd0;
      wbs_ack_q   <= 1'b0;
      wbs_err_q   <= 1'b0;
      wbs_dat_q   <= 32'd0;
      tout_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      reg_cs_q    <= reg_cs_d;
      reg_wr_q    <= reg_wr_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_be_q    <= reg_be_d;
      timer_q     <= timer_d;
      wbs_ack_q   <= wbs_ack_d;
      wbs_err_q   <= wbs_err_d;
      wbs_dat_q   <= wbs_dat_d;
      tout_cnt_q  <= tout_cnt_d;
    end
  end

  // Next-state and next-output logic; completion pulses default low so they
  // last exactly the one RESP cycle.
  always_comb begin
    state_d     = state_q;
    reg_cs_d    = reg_cs_q;
    reg_wr_d    = reg_wr_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_be_d    = reg_be_q;
    timer_d     = timer_q;
    wbs_ack_d   = 1'b0;
    wbs_err_d   = 1'b0;
    wbs_dat_d   = wbs_dat_q;
    tout_cnt_d  = tout_cnt_q;

    case (state_q)
      IDLE: begin
        if (wb.wbs_cyc_i && wb.wbs_stb_i) begin
          reg_cs_d    = 1'b1;
          reg_wr_d    = wb.wbs_we_i;
          reg_addr_d  = wb.wbs_adr_i;
          reg_wdata_d = wb.wbs_dat_i;
          reg_be_d    = wb.wbs_sel_i;
          timer_d     = 8'd0;
          state_d     = BUSY;
        end else begin
          state_d = IDLE;
        end
      end

      BUSY: begin
        if (rb.reg_ack) begin
          // Acknowledge beats a coincident timeout; data captured for writes too.
          reg_cs_d  = 1'b0;
          wbs_dat_d = rb.reg_rdata;
          wbs_ack_d = wb.wbs_cyc_i;
          state_d   = RESP;
        end else if (timer_q == TMO_LIMIT) begin
          // The timeout is counted even if the master has already walked away.
          reg_cs_d   = 1'b0;
          wbs_dat_d  = ERR_DATA;
          wbs_ack_d  = wb.wbs_cyc_i;
          wbs_err_d  = wb.wbs_cyc_i;
          tout_cnt_d = sat_inc8(tout_cnt_q);
          state_d    = RESP;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      RESP: begin
        // Requests and stray acknowledges are ignored for this one cycle.
        state_d = IDLE;
      end

      default: begin
        reg_cs_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  assign rb.reg_cs    = reg_cs_q;
  assign rb.reg_wr    = reg_wr_q;
  assign rb.reg_addr  = reg_addr_q;
  assign rb.reg_wdata = reg_wdata_q;
  assign rb.reg_be    = reg_be_q;
  assign wb.wbs_ack_o = wbs_ack_q;
  assign wb.wbs_err_o = wbs_err_q;
  assign wb.wbs_dat_o = wbs_dat_q;
  assign tout_cnt     = tout_cnt_q;

endmodule

// File: tb/tb_peri_reg_initiator.sv
// Randomised scoreboard bench for peri_reg_initiator. Stimulus pushes the
// expected Wishbone completion and register-bus transaction; two monitors
// pop and compare when the DUT presents them.
`timescale 1ns/1ps

module tb_peri_reg_initiator;

  localparam int          T   = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  typedef struct {
    int          cyc;
    logic [31:0] dat;
    logic        err;
  } wexp_t;

  typedef struct {
    logic        wr;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          len;
  } rexp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] tout_cnt;

  peri_wb_if     wb_if ();
  peri_regbus_if rb_if ();

  peri_reg_initiator #(
    .TIMEOUT_CYC (T),
    .ERR_DATA    (ERR)
  ) dut (
    .mclk      (clk),
    .s_reset_n (rst_n),
    .wb        (wb_if),
    .rb        (rb_if),
    .tout_cnt  (tout_cnt)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc_cnt  = 0;
  int    tout_m   = 0;
  wexp_t wq[$];
  rexp_t rq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Wishbone completion monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_if.wbs_ack_o) begin
        if (wq.size() == 0) begin
          chk("wb_unexpected_ack", {31'd0, wb_if.wbs_ack_o}, 32'd0);
        end else begin
          wexp_t e;
          e = wq.pop_front();
          chk("ack_cycle", 32'(cyc_cnt), 32'(e.cyc));
          chk("wbs_dat_o", wb_if.wbs_dat_o, e.dat);
          chk("wbs_err_o", {31'd0, wb_if.wbs_err_o}, {31'd0, e.err});
        end
      end else begin
        chk("err_without_ack", {31'd0, wb_if.wbs_err_o}, 32'd0);
      end
    end
  end

  // Register-bus monitor: fields stable while cs is high, cs length.
  rexp_t cur;
  logic  cs_prev = 1'b0;
  int    cs_len  = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      cs_prev = 1'b0;
      cs_len  = 0;
    end else begin
      if (rb_if.reg_cs && !cs_prev) begin
        if (rq.size() == 0) begin
          chk("reg_cs_unexpected", {31'd0, rb_if.reg_cs}, 32'd0);
          cur = '{wr: 1'b0, addr: 11'd0, wdata: 32'd0, be: 4'd0, len: -1};
        end else begin
          cur = rq.pop_front();
        end
        cs_len = 0;
      end
      if (rb_if.reg_cs) begin
        cs_len++;
        chk("reg_wr",    {31'd0, rb_if.reg_wr},   {31'd0, cur.wr});
        chk("reg_addr",  {21'd0, rb_if.reg_addr}, {21'd0, cur.addr});
        chk("reg_wdata", rb_if.reg_wdata,         cur.wdata);
        chk("reg_be",    {28'd0, rb_if.reg_be},   {28'd0, cur.be});
      end
      if (!rb_if.reg_cs && cs_prev && cur.len >= 0)
        chk("reg_cs_len", 32'(cs_len), 32'(cur.len));
      cs_prev = rb_if.reg_cs;
    end
  end

  // One transfer. delay: BUSY cycle (0 = first) in which the responder acks;
  // delay > T means no ack inside the window. abort_at >= 0 drops cyc then.
  task automatic xfer(input logic we, input logic [10:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input int delay, input int abort_at);
    logic [31:0] rd;
    int          end_k;
    bit          tmo;
    tmo   = (delay > T);
    end_k = tmo ? T : delay;
    rd    = $urandom;
    wb_if.wbs_cyc_i = 1'b1;
    wb_if.wbs_stb_i = 1'b1;
    wb_if.wbs_we_i  = we;
    wb_if.wbs_adr_i = adr;
    wb_if.wbs_dat_i = dat;
    wb_if.wbs_sel_i = sel;
    @(posedge clk); #1;
    rq.push_back('{wr: we, addr: adr, wdata: dat, be: sel, len: end_k + 1});
    if (abort_at < 0)
      wq.push_back('{cyc: cyc_cnt + end_k + 1, dat: (tmo ? ERR : rd), err: tmo});
    if (tmo && tout_m < 255) tout_m++;
    for (int k = 0; k <= end_k; k++) begin
      rb_if.reg_ack   = (k == delay);
      rb_if.reg_rdata = (k == delay) ? rd : $urandom;
      if (k == abort_at) begin
        wb_if.wbs_cyc_i = 1'b0;
        wb_if.wbs_stb_i = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk("tout_cnt", {24'd0, tout_cnt}, 32'(tout_m));
    rb_if.reg_ack   = (delay == end_k + 1);
    rb_if.reg_rdata = $urandom;
    wb_if.wbs_cyc_i = 1'b0;
    wb_if.wbs_stb_i = 1'b0;
    wb_if.wbs_adr_i = 11'($urandom);
    wb_if.wbs_dat_i = $urandom;
    @(posedge clk); #1;
    rb_if.reg_ack = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_reg_cs"},    {31'd0, rb_if.reg_cs},    32'd0);
    chk({tag, "_reg_wr"},    {31'd0, rb_if.reg_wr},    32'd0);
    chk({tag, "_reg_addr"},  {21'd0, rb_if.reg_addr},  32'd0);
    chk({tag, "_reg_wdata"}, rb_if.reg_wdata,          32'd0);
    chk({tag, "_reg_be"},    {28'd0, rb_if.reg_be},    32'd0);
    chk({tag, "_ack"},       {31'd0, wb_if.wbs_ack_o}, 32'd0);
    chk({tag, "_err"},       {31'd0, wb_if.wbs_err_o}, 32'd0);
    chk({tag, "_dat"},       wb_if.wbs_dat_o,          32'd0);
    chk({tag, "_tout"},      {24'd0, tout_cnt},        32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    wb_if.wbs_cyc_i = 1'b0; wb_if.wbs_stb_i = 1'b0; wb_if.wbs_we_i = 1'b0;
    wb_if.wbs_adr_i = 11'd0; wb_if.wbs_dat_i = 32'd0; wb_if.wbs_sel_i = 4'd0;
    rb_if.reg_ack = 1'b0; rb_if.reg_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    xfer(1'b1, 11'h080, 32'h1234_5678, 4'hF, 1, -1);   // write, ack 1 cycle after cs
    xfer(1'b0, 11'h004, 32'h0, 4'hF, 5, -1);           // read, cs high 6 cycles
    xfer(1'b0, 11'h010, 32'h0, 4'hF, 255, -1);         // timeout: cs 9 cycles
    xfer(1'b0, 11'h014, 32'h0, 4'h3, T, -1);           // ack in the timeout cycle
    xfer(1'b0, 11'h018, 32'h0, 4'hF, T + 1, -1);       // ack lands in RESP: ignored
    xfer(1'b0, 11'h000, 32'h0, 4'hF, 0, -1);           // fastest responder
    xfer(1'b1, 11'h7FC, 32'hCAFE_F00D, 4'h1, 4, 2);    // master abort mid-BUSY
    xfer(1'b0, 11'h020, 32'h0, 4'hF, 255, 3);          // abort, then timeout

    // Reset in the middle of BUSY.
    wb_if.wbs_cyc_i = 1'b1; wb_if.wbs_stb_i = 1'b1; wb_if.wbs_we_i = 1'b1;
    wb_if.wbs_adr_i = 11'h155; wb_if.wbs_dat_i = 32'h0BAD_F00D; wb_if.wbs_sel_i = 4'hC;
    @(posedge clk); #1;
    rq.push_back('{wr: 1'b1, addr: 11'h155, wdata: 32'h0BAD_F00D, be: 4'hC, len: -1});
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    tout_m = 0;
    chk_reset_outputs("midreset");
    wb_if.wbs_cyc_i = 1'b0; wb_if.wbs_stb_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1'b0, 11'h044, 32'h0, 4'hF, 2, -1);

    // Randomised mix.
    for (int i = 0; i < 60; i++) begin
      int r, d, ab;
      r  = $urandom_range(0, 9);
      ab = -1;
      if (r <= 5)      d = $urandom_range(0, T - 1);
      else if (r == 6) d = T;
      else if (r == 7) d = T + 1;
      else if (r == 8) d = 255;
      else begin
        d  = $urandom_range(0, 3);
        ab = $urandom_range(0, d);
      end
      xfer(1'($urandom), 11'($urandom), $urandom, 4'($urandom), d, ab);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Saturation of the timeout counter.
    for (int i = 0; i < 300; i++)
      xfer(1'b0, 11'($urandom), 32'h0, 4'hF, 255, -1);
    chk("tout_saturated", {24'd0, tout_cnt}, 32'd255);

    repeat (3) @(posedge clk);
    #1;
    chk("wb_queue_empty", 32'(wq.size()), 32'd0);
    chk("reg_queue_empty", 32'(rq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
